// File: rtl/rr_buffered_router.sv
// NUM_PORTS x NUM_PORTS buffered router: a FIFO per input, a round-robin arbiter and
// a registered valid/ready output stage per output, routed on an address bit-field.
module rr_buffered_router #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SEL_LSB    = 0,
  localparam int unsigned PW        = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  in_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_PORTS-1:0]             in_valid,
  output logic [NUM_PORTS-1:0]             in_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  out_data,
  output logic [NUM_PORTS*PW-1:0]          out_src,
  output logic [NUM_PORTS-1:0]             out_valid,
  input  logic [NUM_PORTS-1:0]             out_ready,
  output logic [NUM_PORTS-1:0]             fifo_full
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  // Input FIFO storage (no reset needed: validity is tracked by the pointers)
  logic [DATA_WIDTH-1:0] mem_data_q [NUM_PORTS][FIFO_DEPTH];
  logic [PW-1:0]         mem_dest_q [NUM_PORTS][FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q [NUM_PORTS];
  logic [AW-1:0] rd_ptr_q [NUM_PORTS];
  logic [CW-1:0] cnt_q    [NUM_PORTS];
  logic [CW-1:0] cnt_d    [NUM_PORTS];

  logic [NUM_PORTS-1:0]  full, empty, push, pop;
  logic [DATA_WIDTH-1:0] in_data_lane [NUM_PORTS];
  logic [PW-1:0]         in_dest      [NUM_PORTS];
  logic [DATA_WIDTH-1:0] head_data    [NUM_PORTS];
  logic [PW-1:0]         head_dest    [NUM_PORTS];

  // Output stage and arbitration
  logic [DATA_WIDTH-1:0] out_data_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] out_data_d [NUM_PORTS];
  logic [PW-1:0]         out_src_q  [NUM_PORTS];
  logic [PW-1:0]         out_src_d  [NUM_PORTS];
  logic [PW-1:0]         rr_ptr_q   [NUM_PORTS];
  logic [PW-1:0]         rr_ptr_d   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  out_valid_q, out_valid_d;
  logic [NUM_PORTS-1:0]  load_en, gnt_vld;
  logic [PW-1:0]         gnt_idx    [NUM_PORTS];
  logic [PW-1:0]         idx;

  logic unused_addr_bits;
  assign unused_addr_bits = ^in_addr;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      full[i]         = (cnt_q[i] == CW'(FIFO_DEPTH));
      empty[i]        = (cnt_q[i] == '0);
      push[i]         = in_valid[i] && !full[i];
      in_data_lane[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      in_dest[i]      = in_addr[i*ADDR_WIDTH + SEL_LSB +: PW];
      head_data[i]    = mem_data_q[i][rd_ptr_q[i]];
      head_dest[i]    = mem_dest_q[i][rd_ptr_q[i]];
    end
  end

  assign in_ready  = ~full;
  assign fifo_full = full;

  // Per-output round-robin search starting at rr_ptr, wrapping modulo NUM_PORTS
  always_comb begin
    idx = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      load_en[j] = !out_valid_q[j] || out_ready[j];
      gnt_vld[j] = 1'b0;
      gnt_idx[j] = '0;
      for (int off = 0; off < NUM_PORTS; off++) begin
        idx = rr_ptr_q[j] + PW'(off);
        if (load_en[j] && !gnt_vld[j] && !empty[idx] && (head_dest[idx] == PW'(j))) begin
          gnt_vld[j] = 1'b1;
          gnt_idx[j] = idx;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (gnt_vld[j] && (gnt_idx[j] == PW'(i))) begin
          pop[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (push[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (pop[i] && !push[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) begin
        mem_data_q[i][wr_ptr_q[i]] <= in_data_lane[i];
        mem_dest_q[i][wr_ptr_q[i]] <= in_dest[i];
      end
    end
  end

  // Output registers only move when free or draining; otherwise everything holds
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      out_data_d[j]  = out_data_q[j];
      out_src_d[j]   = out_src_q[j];
      out_valid_d[j] = out_valid_q[j];
      rr_ptr_d[j]    = rr_ptr_q[j];
      if (load_en[j]) begin
        if (gnt_vld[j]) begin
          out_data_d[j]  = head_data[gnt_idx[j]];
          out_src_d[j]   = gnt_idx[j];
          out_valid_d[j] = 1'b1;
          rr_ptr_d[j]    = gnt_idx[j] + PW'(1);
        end else begin
          out_valid_d[j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        out_data_q[j] <= '0;
        out_src_q[j]  <= '0;
        rr_ptr_q[j]   <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      for (int j = 0; j < NUM_PORTS; j++) begin
        out_data_q[j] <= out_data_d[j];
        out_src_q[j]  <= out_src_d[j];
        rr_ptr_q[j]   <= rr_ptr_d[j];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      out_data[j*DATA_WIDTH +: DATA_WIDTH] = out_data_q[j];
      out_src[j*PW +: PW]                  = out_src_q[j];
    end
  end

  assign out_valid = out_valid_q;

endmodule
